// File: rtl/lcd_pkg.sv
// Shared types, opcodes and DDRAM line bounds for the HD44780-style bus responder.
package lcd_pkg;

    typedef enum logic [1:0] {
        ST_INIT8 = 2'd0,
        ST_HI    = 2'd1,
        ST_LO    = 2'd2
    } lcd_state_t;

    localparam logic [7:0] CMD_CLR    = 8'h01;
    localparam logic [7:0] CMD_HOME   = 8'h02;
    localparam logic [7:0] HOME_MASK  = 8'hFE;
    localparam logic [7:0] CMD_ENTRY  = 8'h04;
    localparam logic [7:0] ENTRY_MASK = 8'hFC;
    localparam logic [7:0] CMD_SETDD  = 8'h80;
    localparam logic [7:0] SETDD_MASK = 8'h80;

    localparam logic [6:0] LINE0_END   = 7'h27;
    localparam logic [6:0] LINE1_START = 7'h40;
    localparam logic [6:0] LINE1_END   = 7'h67;

    function automatic logic addr_ok(input logic [6:0] a);
        return (a <= LINE0_END) || ((a >= LINE1_START) && (a <= LINE1_END));
    endfunction

    // Cursor step across the two-line map: each line end wraps to the other line's start.
    function automatic logic [6:0] step_addr(input logic [6:0] a, input logic inc);
        logic [6:0] r;
        if (inc) begin
            if (a == LINE0_END)      r = LINE1_START;
            else if (a == LINE1_END) r = 7'h00;
            else                     r = a + 7'd1;
        end else begin
            if (a == 7'h00)            r = LINE1_END;
            else if (a == LINE1_START) r = LINE0_END;
            else                       r = a - 7'd1;
        end
        return r;
    endfunction

endpackage

// File: rtl/lcd_busy_timer.sv
// Busy down-counter: a load starts a busy window of exactly len cycles.
module lcd_busy_timer #(
    parameter int unsigned CNT_W = 17
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] len,
    output logic             busy
);

    logic [CNT_W-1:0] count;

    // Count down and keep busy registered so it drops right as the count expires.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
            busy  <= 1'b0;
        end else if (load) begin
            count <= len;
            busy  <= (len != '0);
        end else if (count != '0) begin
            count <= count - 1'b1;
            busy  <= (count > {{(CNT_W-1){1'b0}}, 1'b1});
        end else begin
            count <= count;
            busy  <= 1'b0;
        end
    end

endmodule

// File: rtl/lcd_bus_responder.sv
// Device end of the 4-bit LCD bus: strobe checking, nibble assembly,
// command execution, cursor tracking and read-back of busy/address.
module lcd_bus_responder
    import lcd_pkg::*;
#(
    parameter int unsigned EN_MIN_CYC = 12,
    parameter int unsigned BUSY_SHORT = 1850,
    parameter int unsigned BUSY_LONG  = 76000,
    parameter int unsigned CNT_W      = 17
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] instruction,
    input  logic       RS,
    input  logic       RW,
    input  logic       Data_En,
    output logic       byte_valid,
    output logic [7:0] byte_out,
    output logic       byte_is_data,
    output logic [3:0] rd_nibble,
    output logic [6:0] ddram_addr,
    output logic       busy,
    output logic       four_bit,
    output logic       proto_err
);

    localparam logic [CNT_W-1:0] EN_MIN     = CNT_W'(EN_MIN_CYC);
    localparam logic [CNT_W-1:0] LEN_SHORT  = CNT_W'(BUSY_SHORT);
    localparam logic [CNT_W-1:0] LEN_LONG   = CNT_W'(BUSY_LONG);
    localparam logic [CNT_W-1:0] WIDTH_SAT  = {CNT_W{1'b1}};

    lcd_state_t       state, state_next;
    logic             en_prev;
    logic [CNT_W-1:0] width;
    logic [3:0]       cap_nib;
    logic             cap_rs, cap_rw;
    logic [3:0]       hi_nib;
    logic             hi_rs;
    logic             id_inc;
    logic             rd_toggle;

    logic             fall, rise, short_err, wr, wr_ok, wr_busy;
    logic             emit, emit_data, exec, err, load, fb_next, id_next;
    logic [7:0]       emit_byte;
    logic [6:0]       addr_next;
    logic [CNT_W-1:0] len;

    lcd_busy_timer #(.CNT_W(CNT_W)) u_busy (
        .clk   (clk),
        .reset (reset),
        .load  (load),
        .len   (len),
        .busy  (busy)
    );

    // Strobe edge detection and classification.
    always_comb begin
        fall      = en_prev & ~Data_En;
        rise      = ~en_prev & Data_En;
        short_err = fall & (width < EN_MIN);
        wr        = fall & ~short_err & ~cap_rw;
        wr_busy   = wr & busy;
        wr_ok     = wr & ~busy;
    end

    // Enable width counter and bus capture while the strobe is high.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            en_prev <= 1'b0;
            width   <= '0;
            cap_nib <= 4'h0;
            cap_rs  <= 1'b0;
            cap_rw  <= 1'b0;
        end else if (Data_En) begin
            en_prev <= 1'b1;
            width   <= (width != WIDTH_SAT) ? width + 1'b1 : width;
            cap_nib <= instruction;
            cap_rs  <= RS;
            cap_rw  <= RW;
        end else begin
            en_prev <= 1'b0;
            width   <= '0;
        end
    end

    // Nibble FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= ST_INIT8;
        else       state <= state_next;
    end

    // Nibble FSM next state; only accepted writes advance it.
    always_comb begin
        state_next = state;
        case (state)
            ST_INIT8: begin
                if (wr_ok && (cap_nib == 4'h2)) state_next = ST_HI;
                else                             state_next = ST_INIT8;
            end
            ST_HI: begin
                if (wr_ok) state_next = ST_LO;
                else       state_next = ST_HI;
            end
            ST_LO: begin
                if (wr_ok) state_next = ST_HI;
                else       state_next = ST_LO;
            end
            default: state_next = ST_INIT8;
        endcase
    end

    // Byte assembly and command execution for the accepting cycle.
    always_comb begin
        emit      = 1'b0;
        emit_byte = byte_out;
        emit_data = byte_is_data;
        exec      = 1'b0;
        err       = short_err | wr_busy;
        load      = 1'b0;
        len       = LEN_SHORT;
        fb_next   = four_bit;
        id_next   = id_inc;
        addr_next = ddram_addr;
        if (wr_ok) begin
            case (state)
                ST_INIT8: begin
                    emit      = 1'b1;
                    emit_byte = {cap_nib, 4'h0};
                    emit_data = 1'b0;
                    load      = 1'b1;
                    if (cap_nib == 4'h2)      fb_next = 1'b1;
                    else if (cap_nib == 4'h3) fb_next = four_bit;
                    else                      err = 1'b1;
                end
                ST_HI: begin
                    emit = 1'b0;
                end
                ST_LO: begin
                    emit      = 1'b1;
                    exec      = 1'b1;
                    emit_byte = {hi_nib, cap_nib};
                    emit_data = hi_rs;
                    if (cap_rs != hi_rs) err = 1'b1;
                    else                 err = short_err | wr_busy;
                end
                default: emit = 1'b0;
            endcase
        end else begin
            emit = 1'b0;
        end

        if (exec) begin
            load = 1'b1;
            if (emit_data) begin
                addr_next = step_addr(ddram_addr, id_inc);
            end else if (emit_byte == CMD_CLR) begin
                addr_next = 7'h00;
                id_next   = 1'b1;
                len       = LEN_LONG;
            end else if ((emit_byte & HOME_MASK) == CMD_HOME) begin
                addr_next = 7'h00;
                len       = LEN_LONG;
            end else if ((emit_byte & ENTRY_MASK) == CMD_ENTRY) begin
                id_next = emit_byte[1];
            end else if ((emit_byte & SETDD_MASK) == CMD_SETDD) begin
                addr_next = emit_byte[6:0];
                if (!addr_ok(emit_byte[6:0])) err = 1'b1;
                else                          err = err;
            end else begin
                len = LEN_SHORT;
            end
        end else begin
            load = load;
        end
    end

    // Registered outputs, cursor and entry-mode state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            byte_valid   <= 1'b0;
            byte_out     <= 8'h00;
            byte_is_data <= 1'b0;
            proto_err    <= 1'b0;
            four_bit     <= 1'b0;
            ddram_addr   <= 7'h00;
            id_inc       <= 1'b1;
            hi_nib       <= 4'h0;
            hi_rs        <= 1'b0;
        end else begin
            byte_valid <= emit;
            proto_err  <= err;
            four_bit   <= fb_next;
            ddram_addr <= addr_next;
            id_inc     <= id_next;
            if (emit) begin
                byte_out     <= emit_byte;
                byte_is_data <= emit_data;
            end
            if (wr_ok && (state == ST_HI)) begin
                hi_nib <= cap_nib;
                hi_rs  <= cap_rs;
            end
        end
    end

    // Read-back: each read rise alternates between {busy, addr[6:4]} and addr[3:0].
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_nibble <= 4'h0;
            rd_toggle <= 1'b0;
        end else if (fall && !cap_rw) begin
            rd_toggle <= 1'b0;
        end else if (rise && RW) begin
            rd_nibble <= rd_toggle ? ddram_addr[3:0] : {busy, ddram_addr[6:4]};
            rd_toggle <= ~rd_toggle;
        end
    end

endmodule
